// File: rtl/jts16_shadow_dump.sv
// jts16_shadow_dump
// -----------------
// Shadow-RAM capture and dump engine for S16-family cores. CPU writes to up
// to CH RAM regions are mirrored into an internal 16-bit copy (2**AW words per
// channel). On request the whole copy is streamed out one byte at a time,
// upper byte first, over a valid/ready port that tolerates back-pressure.
//
// Optional feature macro: JTS16_SHADOW_FREEZE_EN
//   defined   : CPU writes are dropped while dump_busy is high, which gives a
//               coherent snapshot. Any dropped write sets the sticky 'dirty'
//               flag. The flag clears on an accepted dump_start or on rst.
//   undefined : capture continues during a dump and 'dirty' is tied to 0.
//
// Ports
//   clk, rst      : clock and asynchronous active-high reset
//   cs[CH]        : per-channel write select (lowest set index wins)
//   addr[AW]      : CPU word address
//   din[16]       : CPU write data
//   dswn[2]       : active-low byte strobes, [1] = upper byte
//   dump_start    : single-cycle dump request (ignored while busy)
//   dump_abort    : abandons a dump in progress
//   dump_busy     : high from acceptance until done or abort
//   dump_done     : one-cycle pulse after the last byte is accepted
//   dout[8]       : streamed byte
//   dout_addr     : byte address {channel, word, byte} of dout
//   dout_valid    : dout/dout_addr valid
//   dout_ready    : consumer accepts a byte when valid & ready
//   dirty         : a capture write was dropped during a frozen dump
module jts16_shadow_dump #(
  parameter int CH = 4,
  parameter int AW = 14,
  parameter int CW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   cs,
  input  logic [AW-1:0]   addr,
  input  logic [15:0]     din,
  input  logic [1:0]      dswn,
  input  logic            dump_start,
  input  logic            dump_abort,
  output logic            dump_busy,
  output logic            dump_done,
  output logic [7:0]      dout,
  output logic [CW+AW:0]  dout_addr,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            dirty
);

  localparam int PW = CW + AW;            // word pointer width {channel, word}
  localparam int NW = CH * (2**AW);       // number of implemented words
  localparam logic [PW:0]   NWORDS = (PW+1)'(NW);
  localparam logic [PW-1:0] LAST   = PW'(NW - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HI, LO, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [15:0]     wlatch;
  logic [15:0]     rdata;
  logic [15:0]     mem [NW];
  logic            sel_hit;
  logic [CW-1:0]   sel_ch;
  logic            blocked;
  logic            we_hi;
  logic            we_lo;
  logic [PW-1:0]   waddr;
  logic            start_acc;
  logic            hs;

  assign start_acc = (state == IDLE) && dump_start;
  assign hs        = dout_valid && dout_ready;
  assign waddr     = {sel_ch, addr};

`ifdef JTS16_SHADOW_FREEZE_EN
  assign blocked = dump_busy;
`else
  assign blocked = 1'b0;
`endif

  // Channel select: scan from the top down so the lowest set cs bit wins
  always_comb begin
    sel_hit = 1'b0;
    sel_ch  = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (cs[i]) begin
        sel_hit = 1'b1;
        sel_ch  = CW'(i);
      end else begin
        sel_hit = sel_hit;
        sel_ch  = sel_ch;
      end
    end
  end

  // Byte write enables from the active-low strobes
  always_comb begin
    we_hi = sel_hit & ~dswn[1] & ~blocked;
    we_lo = sel_hit & ~dswn[0] & ~blocked;
  end

  // Shadow RAM: byte-wise writes, synchronous read (old data on collision)
  always_ff @(posedge clk) begin
    if (we_hi) mem[waddr][15:8] <= din[15:8];
    if (we_lo) mem[waddr][7:0]  <= din[7:0];
    // Pointers past the implemented channels read as all ones
    if ({1'b0, ptr} < NWORDS) rdata <= mem[ptr];
    else                      rdata <= 16'hffff;
  end

`ifdef JTS16_SHADOW_FREEZE_EN
  // Sticky flag for writes discarded while the snapshot is frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          dirty <= 1'b0;
    else if (start_acc)                               dirty <= 1'b0;
    else if (blocked && sel_hit && dswn != 2'b11)     dirty <= 1'b1;
    else                                              dirty <= dirty;
  end
`else
  assign dirty = 1'b0;
`endif

  // Dump sequencer: FETCH issues the read, WAIT latches it, HI/LO present bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      wlatch     <= 16'h0000;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
      dout       <= 8'h00;
      dout_addr  <= '0;
      dout_valid <= 1'b0;
    end else if (state != IDLE && dump_abort) begin
      // Abort wins over any handshake in the same cycle
      state      <= IDLE;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dump_done <= 1'b0;
          if (start_acc) begin
            ptr       <= '0;
            dump_busy <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          wlatch     <= rdata;
          dout       <= rdata[15:8];
          dout_addr  <= {ptr, 1'b0};
          dout_valid <= 1'b1;
          state      <= HI;
        end
        HI: begin
          if (hs) begin
            dout      <= wlatch[7:0];
            dout_addr <= {ptr, 1'b1};
            state     <= LO;
          end
        end
        LO: begin
          if (hs) begin
            dout_valid <= 1'b0;
            if (ptr == LAST) begin
              dump_busy <= 1'b0;
              dump_done <= 1'b1;
              state     <= DONE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          dump_done <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state      <= IDLE;
          dump_busy  <= 1'b0;
          dump_done  <= 1'b0;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jts16_shadow_dump.sv
// Scoreboard bench for jts16_shadow_dump (CH=4, AW=4). A word-array model of
// the shadow RAM is updated on every CPU write; at each dump start the full
// expected byte stream is queued, and an independent monitor pops and compares
// on every handshake while also checking stall stability and the done pulse.
module tb_jts16_shadow_dump;

  localparam int CH = 4;
  localparam int AW = 4;
  localparam int CW = 2;
  localparam int NW = CH * (2**AW);

  logic          clk;
  logic          rst;
  logic [CH-1:0] cs;
  logic [AW-1:0] addr;
  logic [15:0]   din;
  logic [1:0]    dswn;
  logic          dump_start;
  logic          dump_abort;
  logic          dump_busy;
  logic          dump_done;
  logic [7:0]    dout;
  logic [CW+AW:0] dout_addr;
  logic          dout_valid;
  logic          dout_ready;
  logic          dirty;

  jts16_shadow_dump #(.CH(CH), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cs(cs), .addr(addr), .din(din), .dswn(dswn),
    .dump_start(dump_start), .dump_abort(dump_abort),
    .dump_busy(dump_busy), .dump_done(dump_done),
    .dout(dout), .dout_addr(dout_addr), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dirty(dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int hs_cnt = 0;

  logic [15:0] model [NW];
  logic [14:0] exp_q [$];   // {byte address, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: lowest selected channel takes the write, strobes pick bytes
  task automatic model_write(input logic [3:0] c, input logic [3:0] a,
                             input logic [15:0] d, input logic [1:0] ds);
    bit found;
    int idx;
    found = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (c[i] && !found) begin
        found = 1'b1;
        idx = i * (2**AW) + int'(a);
        if (!ds[1]) model[idx][15:8] = d[15:8];
        if (!ds[0]) model[idx][7:0]  = d[7:0];
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [3:0] c, input logic [3:0] a,
                          input logic [15:0] d, input logic [1:0] ds);
    cs = c; addr = a; din = d; dswn = ds;
    model_write(c, a, d, ds);
    idle_cycle();
    cs = '0; dswn = 2'b11;
  endtask

  task automatic push_expected();
    logic [5:0] wi;
    for (int w = 0; w < NW; w++) begin
      wi = w[5:0];
      exp_q.push_back({wi, 1'b0, model[w][15:8]});
      exp_q.push_back({wi, 1'b1, model[w][7:0]});
    end
  endtask

  // Monitor: scoreboard pops, stall stability and done-pulse placement
  logic        prev_stall = 1'b0;
  logic [15:0] prev_bundle = 16'h0;
  logic        last_hs = 1'b0;
  logic [14:0] ent;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      last_hs = 1'b0;
    end else begin
      if (prev_stall && dump_busy)
        check("stall_hold", {dout_valid, dout, dout_addr}, prev_bundle);
      if (dump_done) begin
        done_cnt++;
        check("done_after_last", {30'd0, exp_q.size() == 0, last_hs}, 32'd3);
      end
      if (dout_valid && dout_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h/%0h required=none", dout_addr, dout);
        end else begin
          ent = exp_q.pop_front();
          check("byte_addr", dout_addr, ent[14:8]);
          check("byte_data", dout, ent[7:0]);
        end
      end
      last_hs = dout_valid && dout_ready;
      prev_stall = dout_valid && !dout_ready && dump_busy;
      prev_bundle = {1'b1, dout, dout_addr};
    end
  end

  // mode 0: ready tied high, mode 1: random ready. abort_after<0: no abort
  task automatic run_dump(input int mode, input int abort_after, input bit mid_write);
    int busy_cyc, base_done, base_hs;
    bit got_done, aborted, wrote;
    push_expected();
    base_done = done_cnt;
    base_hs = hs_cnt;
    got_done = 1'b0; aborted = 1'b0; wrote = 1'b0; busy_cyc = 0;
    dout_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    dump_start = 1'b1;
    idle_cycle();
    dump_start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      cs = '0; dswn = 2'b11; dump_start = 1'b0;
      if (dump_busy) busy_cyc++;
      if (dump_done) begin
        got_done = 1'b1;
        break;
      end
      if (abort_after >= 0 && hs_cnt - base_hs == abort_after) begin
        dout_ready = 1'b0;
        dump_abort = 1'b1;
        idle_cycle();
        dump_abort = 1'b0;
        check("abort_valid_low", dout_valid, 0);
        check("abort_busy_low", dump_busy, 0);
        exp_q.delete();
        aborted = 1'b1;
        break;
      end
      if (mid_write && !wrote && dout_valid && dout_addr == 7'd0) begin
        cs = 4'b0001; addr = 4'd0; din = 16'h0000; dswn = 2'b00;
        wrote = 1'b1;
`ifndef JTS16_SHADOW_FREEZE_EN
        model[0] = 16'h0000;
`endif
      end
      if (cyc == 30) dump_start = 1'b1;   // must be ignored while busy
      dout_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      idle_cycle();
    end
    cs = '0; dswn = 2'b11; dump_start = 1'b0; dout_ready = 1'b1;
    if (aborted) begin
      repeat (5) idle_cycle();
      check("abort_no_done", done_cnt, base_done);
      check("abort_idle_busy", dump_busy, 0);
    end else begin
      idle_cycle();
      check("done_seen", got_done, 1);
      check("stream_complete", exp_q.size(), 0);
      check("done_pulse_count", done_cnt - base_done, 1);
      check("busy_after_done", dump_busy, 0);
      if (mode == 0) check("busy_cycles", busy_cyc, 256);
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; cs = '0; addr = '0; din = '0; dswn = 2'b11;
    dump_start = 1'b0; dump_abort = 1'b0; dout_ready = 1'b1;
    repeat (2) idle_cycle();
    check("rst_busy", dump_busy, 0);
    check("rst_done", dump_done, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_addr", dout_addr, 0);
    check("rst_dirty", dirty, 0);
    rst = 1'b0;
    idle_cycle();

    // Known contents everywhere
    for (int w = 0; w < NW; w++)
      do_write(4'(1 << (w / 16)), 4'(w % 16), 16'($urandom), 2'b00);

    // Directed cases
    do_write(4'b0010, 4'd3, 16'hA55A, 2'b00);   // bytes at 0x26/0x27
    do_write(4'b0100, 4'd5, 16'h1234, 2'b00);
    do_write(4'b0100, 4'd5, 16'hFFEE, 2'b10);   // low byte only -> 12EE
    do_write(4'b0110, 4'd7, 16'hBEEF, 2'b00);   // only ch1 updated
    check("model_a55a", model[16 + 3], 16'hA55A);
    check("model_strobe", model[32 + 5], 16'h12EE);

    run_dump(0, -1, 1'b0);

    // Random writes with multi-hot selects and random strobes
    for (int k = 0; k < 40; k++)
      do_write(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               16'($urandom), 2'($urandom_range(0, 3)));

    run_dump(1, -1, 1'b0);
    run_dump(0, 10, 1'b0);          // abort after 10 bytes
    run_dump(1, -1, 1'b0);          // restart: first byte must be address 0

    run_dump(0, -1, 1'b1);          // write to ch0 word 0 after its fetch
`ifdef JTS16_SHADOW_FREEZE_EN
    check("dirty_set", dirty, 1);
`else
    check("dirty_zero", dirty, 0);
`endif
    run_dump(1, -1, 1'b0);          // RAM contents after the mid-dump write
    check("dirty_after_restart", dirty, 0);

    // Asynchronous reset in the middle of a dump
    push_expected();
    dump_start = 1'b1;
    idle_cycle();
    dump_start = 1'b0;
    repeat (50) idle_cycle();
    rst = 1'b1;
    #1;
    check("midrst_valid", dout_valid, 0);
    check("midrst_busy", dump_busy, 0);
    check("midrst_addr", dout_addr, 0);
    exp_q.delete();
    idle_cycle();
    rst = 1'b0;
    idle_cycle();
    run_dump(0, -1, 1'b0);          // contents survive reset

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jts16_shadow_dump.md
Name: jts16_shadow_dump

Overview:
- Parametrised shadow-RAM capture plus dump engine for S16-family cores.
- Snoops up to CH CPU-side RAM regions (VRAM, char, palette, object RAM, and so on) into internal dual-port copies.
- On request, streams every captured byte out through a valid/ready byte port. The NVRAM/hps dump path, or a debug UART, sits on that port.
- Replaces the fixed four-region, two-clock shadow with a single-clock, sequenced, back-pressure-aware reader.

Parameters:
- CH, 4: number of capture channels, 1..8.
- AW, 14: word-address width of each channel; each channel holds 2**AW 16-bit words.
- CW, 2: channel index width; must satisfy 2**CW >= CH.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cs  in  CH  per-channel write select from the CPU decoder.
- addr  in  AW  CPU word address, bits [AW:1].
- din  in  16  CPU write data.
- dswn  in  2  byte write strobes, active low; [1] is the upper byte.
- dump_start  in  1  single-cycle request to begin a dump.
- dump_abort  in  1  stops a dump in progress.
- dump_busy  out  1  high from accept until done or abort.
- dump_done  out  1  one-cycle pulse after the last byte is accepted.
- dout  out  8  streamed byte.
- dout_addr  out  CW+AW+1  byte address of dout, as {channel, word, byte}.
- dout_valid  out  1  dout and dout_addr are valid.
- dout_ready  in  1  consumer accepts the byte when valid and ready are both high.

Behaviour:
- Reset: all outputs 0 and state IDLE. Shadow RAM contents are not cleared.
- Capture (any state): the write enable is ~dswn gated by the selected channel.
  - If several cs bits are high, the lowest index wins and the others are ignored.
  - Write takes effect at the next clk edge.
- Channel index ch >= CH: reads return 16'hffff; no RAM exists there.
- RAM read port: synchronous, 1-cycle latency.
  - Same-cycle read and write to one word returns the old data.
- Dump FSM states: IDLE, FETCH, WAIT, HI, LO, DONE.
  - IDLE: when dump_start=1, clear the word pointer ptr (CW+AW bits) and go to FETCH. dump_busy=1 from the next cycle.
  - FETCH: drive the read address from ptr; go to WAIT.
  - WAIT: latch the RAM word into wlatch; go to HI.
  - HI: dout=wlatch[15:8], dout_addr={ptr,1'b0}, dout_valid=1. Go to LO on a handshake.
  - LO: dout=wlatch[7:0], dout_addr={ptr,1'b1}. On a handshake:
    - if ptr == CH*2**AW-1, go to DONE;
    - otherwise ptr++ and go to FETCH.
  - DONE: dump_done=1 for one cycle, dump_busy=0, then IDLE.
- Valid/ready rules:
  - dout and dout_addr stay stable while dout_valid=1 and dout_ready=0.
  - dout_valid is never withdrawn without a handshake, except on abort or reset.
- Throughput: 4 clk per word with dout_ready tied high (FETCH, WAIT, HI, LO).
- dump_start while busy: ignored.
- dump_abort in any non-IDLE state: go to IDLE next cycle.
  - dout_valid=0 and dump_busy=0 next cycle.
  - No dump_done pulse.
  - Abort has priority over a same-cycle handshake.
- dump_start and dump_abort together in IDLE: the start is accepted and the abort is ignored, because abort applies only to non-IDLE states.
- Captured word changes after its FETCH: the dump shows the pre-change value. Coherency is not guaranteed unless the optional feature is enabled.
- Asynchronous reset mid-dump: IDLE immediately; the partial stream is discarded.

Optional Feature:
- Macro: JTS16_SHADOW_FREEZE_EN.
- When defined:
  - CPU writes are dropped while dump_busy=1, giving a coherent snapshot.
  - A sticky output port, dirty (1 bit), is set by any dropped write. It is cleared on accepted dump_start and on rst.
- When undefined:
  - Capture continues during a dump.
  - dirty is tied to 0.

Test Plan:
- CH=4, AW=4. Write 16'hA55A to ch1 word 3 with dswn=00, then dump with ready=1 → bytes at dout_addr 0x26/0x27 = 8'hA5/8'h5A; 128 bytes total; dump_done pulse after byte 127.
- Byte strobes: write 16'h1234 with dswn=00, then 16'hFFEE with dswn=10 to the same word → dumped bytes 8'h12/8'hEE.
- Back-pressure: toggle dout_ready with a random 50% pattern → dout and dout_addr stable during stalls; byte sequence identical to the ready=1 run, with no gaps or repeats.
- Abort after 10 bytes, then restart → first byte of the new stream has dout_addr 0; no dump_done for the aborted run.
- cs=4'b0110 write → only ch1 updated; ch2 dumps its prior value.
- FREEZE_EN on: during a dump, write 16'h0000 to ch0 word 0 after that word is fetched → the stream keeps the old value, dirty=1, and the RAM is unchanged on the next dump.
